rv32i_fetch: RTL and testbench

- Multicycle instruction fetch stage, directly upstream of rv32I_decode.
- Owns the PC and issues one request at a time to the instruction memory over a valid/ready request channel with a separate response channel.
- Holds the fetched word in an instruction register, which drives decode's i_fetch_instruction. Presents the word with a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and discards stale responses.

---
 rtl/rv32i_fetch.sv | 122 ++++++++++++
 tb/tb_rv32i_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch.sv
// Multicycle RV32I instruction fetch stage: owns the PC, issues one imem request at a time,
// holds the fetched word for decode and handles redirects, stale responses and fetch faults.
module rv32i_fetch #(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned WORD_SIZE         = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_imem_valid,
  output logic [WORD_SIZE-1:0]         o_imem_addr,
  input  logic                         i_imem_ready,
  input  logic                         i_imem_rvalid,
  input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata,
  input  logic                         i_imem_err,
  output logic                         o_fetch_valid,
  output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction,
  output logic [WORD_SIZE-1:0]         o_fetch_pc,
  input  logic                         i_decode_ready,
  input  logic                         i_redirect_valid,
  input  logic [WORD_SIZE-1:0]         i_redirect_pc,
  output logic                         o_fetch_fault
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(32'h0000_0013);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [WORD_SIZE-1:0]           r_pc;
  logic [WORD_SIZE-1:0]           w_next_pc;
  logic [INSTRUCTION_WIDTH-1:0]   r_instr;
  logic                           r_imem_valid;
  logic                           r_fetch_valid;
  logic                           r_fault;
  logic                           w_accept;
  logic                           w_capture;
  logic                           w_outstanding;

  // Request is only live once the registered valid is up (it stays low for the reset cycle).
  assign w_accept = r_imem_valid & i_imem_ready;

  assign w_outstanding = ((r_state == S_REQ)   & w_accept)
                       | ((r_state == S_WAIT)  & ~i_imem_rvalid)
                       | ((r_state == S_DRAIN) & ~i_imem_rvalid);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_capture    = 1'b0;
    case (r_state)
      S_REQ:   if (w_accept) w_next_state = S_WAIT;
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (i_imem_err) begin
            w_next_state = S_FAULT;
          end else begin
            w_next_state = S_HOLD;
            w_capture    = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (i_decode_ready) begin
          w_next_state = S_REQ;
          w_next_pc    = r_pc + WORD_SIZE'(4);
        end
      end
      S_DRAIN: if (i_imem_rvalid) w_next_state = S_REQ;
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_REQ;
    endcase

    // A redirect in DRAIN stays in DRAIN only while the stale response is still pending;
    // if it lands in the same cycle nothing is left to discard.
    if (i_redirect_valid) begin
      w_next_pc = i_redirect_pc;
      w_capture = 1'b0;
      if (i_redirect_pc[1:0] != 2'b00) begin
        w_next_state = S_FAULT;
      end else if (w_outstanding) begin
        w_next_state = S_DRAIN;
      end else begin
        w_next_state = S_REQ;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_imem_valid  <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      if (w_capture) r_instr <= i_imem_rdata;
      r_imem_valid  <= (w_next_state == S_REQ);
      r_fetch_valid <= (w_next_state == S_HOLD);
      r_fault       <= (w_next_state == S_FAULT);
    end
  end

  // The PC only moves on consumption or redirect, so it doubles as the presented/faulting PC.
  assign o_imem_valid        = r_imem_valid;
  assign o_imem_addr         = r_pc;
  assign o_fetch_valid       = r_fetch_valid;
  assign o_fetch_instruction = r_instr;
  assign o_fetch_pc          = r_pc;
  assign o_fetch_fault       = r_fault;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed self-checking bench for rv32i_fetch: handshakes, stalls, redirects, faults, reset.
module tb_rv32i_fetch;

  logic        clk;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int unsigned checks;
  int unsigned failures;

  rv32i_fetch #(
    .INSTRUCTION_WIDTH(32),
    .WORD_SIZE(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .o_imem_valid       (imem_valid),
    .o_imem_addr        (imem_addr),
    .i_imem_ready       (imem_ready),
    .i_imem_rvalid      (imem_rvalid),
    .i_imem_rdata       (imem_rdata),
    .i_imem_err         (imem_err),
    .o_fetch_valid      (fetch_valid),
    .o_fetch_instruction(fetch_instr),
    .o_fetch_pc         (fetch_pc),
    .i_decode_ready     (decode_ready),
    .i_redirect_valid   (redirect_valid),
    .i_redirect_pc      (redirect_pc),
    .o_fetch_fault      (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (imem_valid !== 1'b0) begin failures++; $display("FAIL rst_imem_valid got=%b exp=0", imem_valid); end
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_fetch_valid got=%b exp=0", fetch_valid); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", fetch_fault); end
    checks++; if (fetch_instr !== 32'h0000_0013) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", fetch_instr); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
    rst = 1'b0;
    step();
    checks++; if (imem_valid !== 1'b1) begin failures++; $display("FAIL rst_release_valid got=%b exp=1", imem_valid); end
  endtask

  task automatic test_sequential();
    decode_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        failures++; $display("FAIL seq_req[%0d] got valid=%b addr=%h exp valid=1 addr=%h", k, imem_valid, imem_addr, 32'(4 * k)); end
      imem_ready = 1'b1;
      step();
      imem_ready  = 1'b0;
      checks++; if (imem_valid !== 1'b0 || fetch_valid !== 1'b0) begin
        failures++; $display("FAIL seq_wait[%0d] got imem_valid=%b fetch_valid=%b exp 0 0", k, imem_valid, fetch_valid); end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0093;
      step();
      imem_rvalid = 1'b0;
      checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0000_0093 || fetch_pc !== 32'(4 * k)) begin
        failures++; $display("FAIL seq_hold[%0d] got v=%b instr=%h pc=%h exp 1 00000093 %h", k, fetch_valid, fetch_instr, fetch_pc, 32'(4 * k)); end
      step();
    end
  endtask

  task automatic test_ready_stall();
    decode_ready = 1'b0;
    imem_ready   = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h10) begin
        failures++; $display("FAIL stall_req[%0d] got valid=%b addr=%h exp 1 00000010", c, imem_valid, imem_addr); end
      step();
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    checks++; if (imem_valid !== 1'b0) begin failures++; $display("FAIL stall_accept got valid=%b exp=0", imem_valid); end
    step();
    checks++; if (imem_valid !== 1'b0 || fetch_valid !== 1'b0) begin
      failures++; $display("FAIL stall_wait got imem_valid=%b fetch_valid=%b exp 0 0", imem_valid, fetch_valid); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hA5A5_0010;
    step();
    imem_rvalid = 1'b0;
    checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hA5A5_0010 || fetch_pc !== 32'h10) begin
      failures++; $display("FAIL stall_capture got v=%b instr=%h pc=%h exp 1 a5a50010 00000010", fetch_valid, fetch_instr, fetch_pc); end
  endtask

  task automatic test_decode_stall();
    decode_ready = 1'b0;
    for (int unsigned c = 0; c < 5; c++) begin
      step();
      checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hA5A5_0010 || fetch_pc !== 32'h10 || imem_valid !== 1'b0) begin
        failures++; $display("FAIL hold_stable[%0d] got v=%b instr=%h pc=%h req=%b exp 1 a5a50010 00000010 0", c, fetch_valid, fetch_instr, fetch_pc, imem_valid); end
    end
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h14 || fetch_valid !== 1'b0) begin
      failures++; $display("FAIL hold_release got req=%b addr=%h v=%b exp 1 00000014 0", imem_valid, imem_addr, fetch_valid); end
  endtask

  task automatic test_redirect_wait();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h20) begin
      failures++; $display("FAIL redir_req got req=%b addr=%h exp 1 00000020", imem_valid, imem_addr); end
    imem_ready = 1'b1;
    step();
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_valid !== 1'b0 || fetch_valid !== 1'b0) begin
      failures++; $display("FAIL redir_drain got req=%b v=%b exp 0 0", imem_valid, fetch_valid); end
    step();
    checks++; if (imem_valid !== 1'b0) begin failures++; $display("FAIL redir_drain_hold got req=%b exp 0", imem_valid); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h100 || fetch_valid !== 1'b0 || fetch_instr !== 32'hA5A5_0010) begin
      failures++; $display("FAIL redir_discard got req=%b addr=%h v=%b instr=%h exp 1 00000100 0 a5a50010", imem_valid, imem_addr, fetch_valid, fetch_instr); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b1 || fetch_pc !== 32'h102 || imem_valid !== 1'b0 || fetch_valid !== 1'b0) begin
      failures++; $display("FAIL misalign_fault got f=%b pc=%h req=%b v=%b exp 1 00000102 0 0", fetch_fault, fetch_pc, imem_valid, fetch_valid); end
    step();
    step();
    checks++; if (fetch_fault !== 1'b1 || imem_valid !== 1'b0) begin
      failures++; $display("FAIL misalign_held got f=%b req=%b exp 1 0", fetch_fault, imem_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b0 || imem_valid !== 1'b1 || imem_addr !== 32'h200) begin
      failures++; $display("FAIL misalign_recover got f=%b req=%b addr=%h exp 0 1 00000200", fetch_fault, imem_valid, imem_addr); end
  endtask

  task automatic test_imem_err();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    imem_ready     = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_err    = 1'b1;
    imem_rdata  = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    checks++; if (fetch_fault !== 1'b1 || fetch_pc !== 32'h40 || fetch_valid !== 1'b0 || imem_valid !== 1'b0) begin
      failures++; $display("FAIL err_fault got f=%b pc=%h v=%b req=%b exp 1 00000040 0 0", fetch_fault, fetch_pc, fetch_valid, imem_valid); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    imem_ready     = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0093;
    step();
    imem_rvalid = 1'b0;
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFFC || fetch_fault !== 1'b0) begin
      failures++; $display("FAIL wrap_hold got v=%b pc=%h f=%b exp 1 fffffffc 0", fetch_valid, fetch_pc, fetch_fault); end
    decode_ready = 1'b1;
    step();
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL wrap_next got req=%b addr=%h exp 1 00000000", imem_valid, imem_addr); end
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_0093;
    step();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h300 || fetch_valid !== 1'b0) begin
      failures++; $display("FAIL hold_redirect got req=%b addr=%h v=%b exp 1 00000300 0", imem_valid, imem_addr, fetch_valid); end
    imem_ready = 1'b1;
    step();
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    step();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h400 || fetch_valid !== 1'b0 || fetch_instr !== 32'h0020_0093) begin
      failures++; $display("FAIL wait_rvalid_redirect got req=%b addr=%h v=%b instr=%h exp 1 00000400 0 00200093", imem_valid, imem_addr, fetch_valid, fetch_instr); end
  endtask

  task automatic test_reset_mid_wait();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_instr !== 32'h0000_0013 || fetch_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      failures++; $display("FAIL async_reset got req=%b addr=%h instr=%h v=%b f=%b exp 0 00000000 00000013 0 0", imem_valid, imem_addr, fetch_instr, fetch_valid, fetch_fault); end
    step();
    rst = 1'b0;
    step();
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_first_req got req=%b addr=%h exp 1 00000000", imem_valid, imem_addr); end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    imem_err       = 1'b0;
    decode_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_sequential();
    test_ready_stall();
    test_decode_stall();
    test_redirect_wait();
    test_misaligned();
    test_imem_err();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
